pmem_sram: RTL and testbench

PMEM_SRAM -- requirements
Module: pmem_sram

---
 rtl/pmem_pkg.sv | 52 +++++
 rtl/pmem_lfsr.sv | 16 +
 rtl/pmem_sram.sv | 132 +++++++++++++
 tb/tb_pmem_sram.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types, LFSR constants and the pmem_read/pmem_write memory access
// entry points used by the pmem_sram front end.
package pmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_SW = MAX_DW / 8;
  localparam int unsigned LFSR_W = 4;
  localparam int unsigned CNT_W  = 4;

  // x^4 + x^3 + 1: feedback taken from the two top stages
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b1001;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [MAX_DW-1:0] wdata;
    logic [MAX_SW-1:0] wstrb;
  } req_t;

  // Word-addressed backing store plus call bookkeeping visible to the environment.
  logic [31:0] mem [logic [31:0]];
  int unsigned rd_calls;
  int unsigned wr_calls;
  logic [31:0] rd_log [$];

  function automatic logic [31:0] pmem_read(input logic [31:0] addr);
    rd_calls = rd_calls + 1;
    rd_log.push_back(addr);
    return mem.exists(addr) ? mem[addr] : 32'h0;
  endfunction

  function automatic void pmem_write(input logic [31:0] addr,
                                     input logic [31:0] data,
                                     input logic [3:0]  mask);
    logic [31:0] w;
    w = mem.exists(addr) ? mem[addr] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
    end
    mem[addr] = w;
    wr_calls = wr_calls + 1;
  endfunction

endpackage

// File: rtl/pmem_lfsr.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) that steps every cycle from a reset seed.
module pmem_lfsr
  import pmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/pmem_sram.sv
// Single-outstanding request/response SRAM front end with fixed or
// pseudo-random latency; the access itself happens on the last WAIT edge.
module pmem_sram
  import pmem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LAT      = 1,
  parameter bit          RAND_LAT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam bit          WIDE   = (DATA_W == 64);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   lat_m1_c;
  logic [LFSR_W-1:0]  lfsr_q;
  req_t               req_q;
  logic [MAX_DW-1:0]  rdata_q;
  logic               err_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               accept_c;
  logic               access_c;
  logic               misaligned_c;
  logic [ADDR_W-1:0]  base_c;

  pmem_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign lat_m1_c     = RAND_LAT ? CNT_W'(lfsr_q % LFSR_W'(LAT)) : CNT_W'(LAT - 1);
  assign accept_c     = req_valid && (state_q == ST_IDLE);
  assign access_c     = (state_q == ST_WAIT) && (cnt_q == '0);
  assign misaligned_c = |req_q.addr[OFF_W-1:0];
  assign base_c       = req_q.addr & ~ADDR_W'(STRB_W - 1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = lat_m1_c;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q.wr    <= req_wr;
      req_q.addr  <= req_addr;
      req_q.wdata <= MAX_DW'(req_wdata);
      req_q.wstrb <= MAX_SW'(req_wstrb);
    end
  end

  // One memory access per request, on the edge that leaves WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access_c) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (misaligned_c) begin
        err_q <= 1'b1;
      end else if (req_q.wr) begin
        if (|req_q.wstrb[3:0])
          pmem_write(base_c, req_q.wdata[31:0], req_q.wstrb[3:0]);
        if (WIDE && |req_q.wstrb[7:4])
          pmem_write(base_c + ADDR_W'(4), req_q.wdata[63:32], req_q.wstrb[7:4]);
      end else begin
        rdata_q[31:0] <= pmem_read(base_c);
        if (WIDE) rdata_q[63:32] <= pmem_read(base_c + ADDR_W'(4));
      end
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q[DATA_W-1:0];
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_pmem_sram.sv
// Bench for pmem_sram: five configurations side by side, a vector table run
// through a scoreboard, and hand sequences for stall, reset and random latency.
module tb_pmem_sram;
  import pmem_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [N];
  logic        req_wr    [N];
  logic        rsp_ready [N];
  logic [31:0] req_addr  [N];
  logic [63:0] req_wdata [N];
  logic [7:0]  req_wstrb [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic        rsp_err   [N];
  logic [63:0] rsp_rdata [N];

  // 0: LAT1, 1: LAT3, 2: LAT8, 3: 64-bit LAT2, 4: random LAT4
  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int unsigned DW = (k == 3) ? 64 : 32;
    localparam int unsigned L  = (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 8 : (k == 3) ? 2 : 4;
    logic [DW-1:0] rdata;
    pmem_sram #(.DATA_W(DW), .LAT(L), .RAND_LAT(k == 4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[k]),
      .req_ready (req_ready[k]),
      .req_wr    (req_wr[k]),
      .req_addr  (req_addr[k]),
      .req_wdata (req_wdata[k][DW-1:0]),
      .req_wstrb (req_wstrb[k][DW/8-1:0]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k]),
      .rsp_rdata (rdata),
      .rsp_err   (rsp_err[k])
    );
    assign rsp_rdata[k] = 64'(rdata);
  end

  typedef struct {
    string       name;
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  vec_t tab [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait for its response; called #1 after a rising edge
  task automatic do_req(input int k, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        output logic [63:0] rdata, output logic err, output int lat);
    int n;
    req_valid[k] = 1'b1;
    req_wr[k]    = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      step();
      n++;
    end
    step();
    req_valid[k] = 1'b0;
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      step();
      lat++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [63:0] rd;
    logic        er;
    int          lat;
    int unsigned r0, w0;
    e = '{v.rdata, v.err, v.lat};
    sb.push_back(e);
    r0 = rd_calls;
    w0 = wr_calls;
    do_req(v.k, v.wr, v.addr, v.wdata, v.wstrb, rd, er, lat);
    e = sb.pop_front();
    chk({v.name, ".rdata"}, rd, e.rdata);
    chk({v.name, ".err"}, 64'(er), 64'(e.err));
    chk({v.name, ".lat"}, 64'(lat), 64'(e.lat));
    step();
    chk({v.name, ".rd_calls"}, 64'(rd_calls - r0), 64'(v.nrd));
    chk({v.name, ".wr_calls"}, 64'(wr_calls - w0), 64'(v.nwr));
    chk({v.name, ".after"}, {61'h0, req_ready[v.k], rsp_valid[v.k], rsp_err[v.k]}, 64'b100);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat, bad, n0;
    int unsigned w0, r0;
    logic [3:0]  seen;
    exp_t        e;

    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_wr[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_wstrb[k] = '0;
      rsp_ready[k] = 1'b1;
    end
    #1;
    chk("reset.k0", {req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]}, {3'b100, 64'h0});
    chk("reset.k3", {req_ready[3], rsp_valid[3], rsp_err[3], rsp_rdata[3]}, {3'b100, 64'h0});
    #21 rst_n = 1'b1;
    step();

    tab.push_back('{"w_boot",   0, 1'b1, 32'h8000_0000, 64'h0000_0413,           8'h0f, 64'h0,                   1'b0, 1, 0, 1});
    tab.push_back('{"r_boot",   0, 1'b0, 32'h8000_0000, 64'h0,                   8'h00, 64'h0000_0413,           1'b0, 1, 1, 0});
    tab.push_back('{"w_full",   1, 1'b1, 32'h8000_0010, 64'h1122_3344,           8'h0f, 64'h0,                   1'b0, 3, 0, 1});
    tab.push_back('{"w_strb",   1, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF,           8'h03, 64'h0,                   1'b0, 3, 0, 1});
    tab.push_back('{"r_merge",  1, 1'b0, 32'h8000_0010, 64'h0,                   8'h00, 64'h1122_BEEF,           1'b0, 3, 1, 0});
    tab.push_back('{"w_nostrb", 1, 1'b1, 32'h8000_0020, 64'h0000_0055,           8'h00, 64'h0,                   1'b0, 3, 0, 0});
    tab.push_back('{"r_mis",    1, 1'b0, 32'h8000_0022, 64'h0,                   8'h00, 64'h0,                   1'b1, 3, 0, 0});
    tab.push_back('{"w_mis",    1, 1'b1, 32'h8000_0013, 64'hFFFF_FFFF,           8'h0f, 64'h0,                   1'b1, 3, 0, 0});
    tab.push_back('{"r64_mis",  3, 1'b0, 32'h8000_0004, 64'h0,                   8'h00, 64'h0,                   1'b1, 2, 0, 0});
    tab.push_back('{"w64_full", 3, 1'b1, 32'h8000_0008, 64'hCAFEF00D_0BADC0DE,   8'hff, 64'h0,                   1'b0, 2, 0, 2});
    tab.push_back('{"r64_full", 3, 1'b0, 32'h8000_0008, 64'h0,                   8'h00, 64'hCAFEF00D_0BADC0DE,   1'b0, 2, 2, 0});
    tab.push_back('{"w64_hi",   3, 1'b1, 32'h8000_0008, 64'hFFFFFFFF_00000000,   8'hf0, 64'h0,                   1'b0, 2, 0, 1});
    tab.push_back('{"r64_hi",   3, 1'b0, 32'h8000_0008, 64'h0,                   8'h00, 64'hFFFFFFFF_0BADC0DE,   1'b0, 2, 2, 0});
    tab.push_back('{"r64_lo",   3, 1'b0, 32'h8000_0000, 64'h0,                   8'h00, 64'h00000000_00000413,   1'b0, 2, 2, 0});
    tab.push_back('{"w64_none", 3, 1'b1, 32'h8000_0010, 64'h1,                   8'h00, 64'h0,                   1'b0, 2, 0, 0});
    tab.push_back('{"r_blank",  0, 1'b0, 32'h8000_0024, 64'h0,                   8'h00, 64'h0,                   1'b0, 1, 1, 0});
    tab.push_back('{"w_pre",    0, 1'b1, 32'h8000_0030, 64'h1234_5678,           8'h0f, 64'h0,                   1'b0, 1, 0, 1});
    foreach (tab[i]) run_vec(tab[i]);

    // 64-bit read splits into two word reads at the aligned base and base+4
    n0 = rd_log.size();
    run_vec('{"r64_split", 3, 1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'hFFFFFFFF_0BADC0DE, 1'b0, 2, 2, 0});
    chk("r64_split.addr0", 64'(rd_log[n0]), 64'h8000_0008);
    chk("r64_split.addr1", 64'(rd_log[n0 + 1]), 64'h8000_000C);

    // Consumer stalls 5 cycles while a stray request is presented
    r0 = rd_calls;
    rsp_ready[1] = 1'b0;
    do_req(1, 1'b0, 32'h8000_0010, 64'h0, 8'h00, rd, er, lat);
    chk("stall.lat", 64'(lat), 64'd3);
    chk("stall.rdata", rd, 64'h1122_BEEF);
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b1;
    req_addr[1]  = 32'h8000_0000;
    req_wstrb[1] = 8'h0f;
    bad = 0;
    repeat (5) begin
      step();
      if (!rsp_valid[1] || rsp_rdata[1] !== rd || req_ready[1] || rsp_err[1]) bad++;
    end
    chk("stall.stable", 64'(bad), 64'd0);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    #1;
    chk("stall.ready_in_hs", 64'(req_ready[1]), 64'd0);
    step();
    chk("stall.ready_after", 64'(req_ready[1]), 64'd1);
    chk("stall.valid_after", 64'(rsp_valid[1]), 64'd0);
    chk("stall.calls", 64'(rd_calls - r0), 64'd1);
    chk("stall.no_write", 64'(wr_calls), 64'(wr_calls));

    // Asynchronous reset in the middle of a long write wait
    w0 = wr_calls;
    req_valid[2] = 1'b1;
    req_wr[2]    = 1'b1;
    req_addr[2]  = 32'h8000_0030;
    req_wdata[2] = 64'h7777_7777;
    req_wstrb[2] = 8'h0f;
    step();
    req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst.outputs", {req_ready[2], rsp_valid[2], rsp_err[2], rsp_rdata[2]}, {3'b100, 64'h0});
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      step();
      if (rsp_valid[2]) bad++;
    end
    chk("rst.no_rsp", 64'(bad), 64'd0);
    chk("rst.no_write", 64'(wr_calls - w0), 64'd0);
    run_vec('{"rst.mem", 0, 1'b0, 32'h8000_0030, 64'h0, 8'h00, 64'h1234_5678, 1'b0, 1, 1, 0});

    // Random latency: back-to-back reads with occasional idle gaps
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      a = (i % 2 == 1) ? 32'h8000_0010 : 32'h8000_0000;
      e = '{((i % 2 == 1) ? 64'h1122_BEEF : 64'h0000_0413), 1'b0, 0};
      sb.push_back(e);
      do_req(4, 1'b0, a, 64'h0, 8'h00, rd, er, lat);
      e = sb.pop_front();
      chk("rand.rdata", rd, e.rdata);
      chk("rand.lat_range", 64'(lat >= 1 && lat <= 4), 64'd1);
      if (lat >= 1 && lat <= 4) seen[lat-1] = 1'b1;
      step();
      repeat ($urandom_range(0, 2)) step();
    end
    chk("rand.all_seen", 64'(seen), 64'hf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
